// File: rtl/usb_tx_serializer_pkg.sv
// Shared types and constants for the low-speed USB transmit serializer.
// Symbol encoding is {D+, D-}: low-speed J drives D- high, K drives D+ high.
package usb_tx_serializer_pkg;

    typedef enum logic [1:0] {
        D_SE0 = 2'b00,
        D_J   = 2'b01,
        D_K   = 2'b10,
        D_SE1 = 2'b11
    } d_port_t;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        ABORT,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam int         STUFF_LIMIT = 6;
    localparam int         ABORT_BITS  = 7;

    function automatic d_port_t nrzi_toggle(input d_port_t sym);
        return (sym == D_J) ? D_K : D_J;
    endfunction

endpackage

// File: rtl/usb_tx_serializer_nrzi_stuff.sv
// NRZI line-state holder and consecutive-ones counter, advanced once per bit strobe.
// A stuff bit is simply a strobe carrying a 0; the caller decides when one is owed.
module usb_nrzi_stuff
    import usb_tx_serializer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       strobe,
    input  logic       bit_in,
    output logic [1:0] sym,
    output logic       stuff_pending
);

    d_port_t    sym_q;
    logic [2:0] ones_q;

    assign sym           = sym_q;
    assign stuff_pending = (ones_q == 3'(STUFF_LIMIT));

    // A 0 toggles the line and restarts the run of ones; a 1 holds the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_q  <= D_J;
            ones_q <= '0;
        end else if (clear) begin
            sym_q  <= D_J;
            ones_q <= '0;
        end else if (strobe) begin
            if (!bit_in) begin
                sym_q  <= nrzi_toggle(sym_q);
                ones_q <= '0;
            end else begin
                ones_q <= ones_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_serializer.sv
// Low-speed USB transmit front end: SYNC, NRZI data with bit stuffing, EOP.
// Optional abort (deliberate stuff violation) is built only with USB_TX_ABORT_EN.
module usb_tx_serializer
    import usb_tx_serializer_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [1:0] d,
    output logic       oe,
    output logic       busy
`ifdef USB_TX_ABORT_EN
    ,
    input  logic       tx_abort
`endif
);

    localparam int TW = $clog2(CLK_DIV);

    tx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    shreg_q, shreg_d;
    logic          wrap, fetch, abort_now;
    logic          strobe, bit_out, clear, stuff_pending;
    logic [1:0]    sym;

    assign wrap = (timer_q == TW'(CLK_DIV - 1));

`ifdef USB_TX_ABORT_EN
    logic abort_q;

    // An abort request is only honoured while data bytes are on the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            abort_q <= 1'b0;
        else if (state_q == IDLE)
            abort_q <= 1'b0;
        else if (state_q == DATA && tx_abort)
            abort_q <= 1'b1;
    end

    assign abort_now = abort_q | (state_q == DATA && tx_abort);
`else
    assign abort_now = 1'b0;
`endif

    // A byte boundary with a stuff bit still owed is postponed until that stuff bit ends.
    assign fetch    = (state_q == SYNC || state_q == DATA) && wrap && !stuff_pending
                      && (idx_q == 3'd7) && !abort_now;
    assign tx_ready = fetch && tx_valid;
    assign busy     = (state_q != IDLE);
    assign oe       = busy;

    usb_nrzi_stuff u_nrzi (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .strobe        (strobe),
        .bit_in        (bit_out),
        .sym           (sym),
        .stuff_pending (stuff_pending)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            if (state_q == IDLE || wrap)
                timer_q <= '0;
            else
                timer_q <= timer_q + TW'(1);
        end
    end

    // shreg holds the bits of the current byte not yet on the line, next bit in [0].
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        strobe  = 1'b0;
        bit_out = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = SYNC;
                    idx_d   = 3'd0;
                    shreg_d = SYNC_BYTE[7:1];
                    strobe  = 1'b1;
                    bit_out = SYNC_BYTE[0];
                end
            end
            SYNC, DATA: begin
                if (wrap) begin
                    if (abort_now) begin
`ifdef USB_TX_ABORT_EN
                        state_d = ABORT;
                        idx_d   = 3'd0;
`endif
                    end else if (stuff_pending) begin
                        strobe  = 1'b1;
                        bit_out = 1'b0;
                    end else if (idx_q == 3'd7) begin
                        idx_d = 3'd0;
                        if (tx_valid) begin
                            state_d = DATA;
                            shreg_d = tx_data[7:1];
                            strobe  = 1'b1;
                            bit_out = tx_data[0];
                        end else begin
                            state_d = EOP_SE0;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[6:1]};
                        strobe  = 1'b1;
                        bit_out = shreg_q[0];
                    end
                end
            end
`ifdef USB_TX_ABORT_EN
            ABORT: begin
                if (wrap) begin
                    if (idx_q == 3'(ABORT_BITS - 1)) begin
                        state_d = EOP_SE0;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`endif
            EOP_SE0: begin
                if (wrap) begin
                    if (idx_q == 3'd1) begin
                        state_d = EOP_J;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (wrap) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                clear   = 1'b1;
            end
        endcase
    end

    always_comb begin
        d = D_J;
        case (state_q)
            IDLE, EOP_J: d = D_J;
            EOP_SE0:     d = D_SE0;
            default:     d = sym;
        endcase
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboard bench for usb_tx_serializer: a packet-level model predicts every bit-time
// symbol and tx_ready offset; an independent monitor compares the line against it.
module tb_usb_tx_serializer;

    localparam int         CLK_DIV = 16;
    localparam logic [1:0] LJ      = 2'b01;
    localparam logic [1:0] LK      = 2'b10;
    localparam logic [1:0] LSE0    = 2'b00;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic [1:0] d;
    logic       oe;
    logic       busy;
`ifdef USB_TX_ABORT_EN
    logic       tx_abort = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] sym_q[$];
    int         rdy_q[$];
    int         len_q[$];
    logic [7:0] pkt[$];

    always #21 clk = ~clk;

    usb_tx_serializer #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .d        (d),
        .oe       (oe),
        .busy     (busy)
`ifdef USB_TX_ABORT_EN
        ,
        .tx_abort (tx_abort)
`endif
    );

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line prediction from first principles: SYNC + bytes LSB-first, stuff after six 1s, NRZI, EOP.
    task automatic build_model(input logic [7:0] bytes[$]);
        logic [7:0] sync_byte = 8'h80;
        logic [7:0] cur;
        logic [1:0] lvl = LJ;
        int         ones = 0;
        int         t = 0;
        logic       b;
        for (int i = 0; i < 8 + 8 * bytes.size(); i++) begin
            if (i < 8) begin
                b = sync_byte[i];
            end else begin
                cur = bytes[(i - 8) / 8];
                b   = cur[(i - 8) % 8];
            end
            if (ones == 6) begin
                lvl  = (lvl == LJ) ? LK : LJ;
                ones = 0;
                sym_q.push_back(lvl);
                t++;
            end
            if (i >= 8 && (i - 8) % 8 == 0)
                rdy_q.push_back(t * CLK_DIV - 1);
            if (b == 1'b0) begin
                lvl  = (lvl == LJ) ? LK : LJ;
                ones = 0;
            end else begin
                ones++;
            end
            sym_q.push_back(lvl);
            t++;
        end
        if (ones == 6) begin
            lvl = (lvl == LJ) ? LK : LJ;
            sym_q.push_back(lvl);
            t++;
        end
        sym_q.push_back(LSE0);
        sym_q.push_back(LSE0);
        sym_q.push_back(LJ);
        len_q.push_back(t + 3);
    endtask

    // Monitor: aligns on oe rising, samples mid-bit, logs every tx_ready by offset.
    initial begin : monitor
        int  len;
        int  exp;
        bit  aborted;
        forever begin
            @(negedge clk);
            if (reset && oe) begin
                if (len_q.size() == 0) begin
                    check_output("unexpected_packet", 1, 0);
                    while (oe) @(negedge clk);
                end else begin
                    len     = len_q.pop_front();
                    aborted = 1'b0;
                    for (int c = 0; c < len * CLK_DIV; c++) begin
                        if (c > 0) @(negedge clk);
                        if (!reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (c % CLK_DIV == CLK_DIV / 2) begin
                            exp = (sym_q.size() > 0) ? int'(sym_q.pop_front()) : -1;
                            check_output($sformatf("sym_bit%0d", c / CLK_DIV), int'(d), exp);
                            check_output("oe_during", int'(oe), 1);
                        end
                        if (tx_ready) begin
                            exp = (rdy_q.size() > 0) ? rdy_q.pop_front() : -1;
                            check_output("tx_ready_offset", c, exp);
                        end
                    end
                    if (aborted) begin
                        sym_q.delete();
                        rdy_q.delete();
                        len_q.delete();
                    end else begin
                        @(negedge clk);
                        check_output("oe_end", int'(oe), 0);
                        check_output("busy_end", int'(busy), 0);
                        check_output("ready_missing", rdy_q.size(), 0);
                    end
                end
            end
        end
    end

    task automatic wait_busy_low(input int limit);
        int guard = 0;
        while (busy && guard < limit) begin
            @(negedge clk);
            guard++;
        end
        if (busy) check_output("busy_timeout", 1, 0);
    endtask

    // Drives one packet; tx_data/tx_valid carry junk between fetches to prove they are ignored.
    task automatic apply_stimulus(input logic [7:0] bytes[$]);
        int n = bytes.size();
        int guard;
        int junk;
        build_model(bytes);
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = (n > 0) ? bytes[0] : 8'($urandom);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!busy && guard < 4);
        if (!busy) begin
            check_output("start_timeout", 0, 1);
            tx_valid = 1'b0;
            return;
        end
        if (n == 0) begin
            @(posedge clk); #1;
            tx_valid = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            guard = 0;
            while (!tx_ready && guard < 600) begin
                @(negedge clk);
                guard++;
            end
            if (!tx_ready) begin
                check_output("ready_timeout", 0, 1);
                tx_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
            junk = $urandom_range(0, 40);
            for (int j = 0; j < junk; j++) begin
                tx_valid = 1'($urandom);
                tx_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            tx_valid = (k + 1 < n);
            tx_data  = (k + 1 < n) ? bytes[k + 1] : 8'($urandom);
        end
        wait_busy_low(3000);
        @(negedge clk);
    endtask

    initial begin : stimulus
        int bad;
        int n;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_output("reset_d", int'(d), int'(LJ));
        check_output("reset_oe", int'(oe), 0);
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_ready", int'(tx_ready), 0);
        reset = 1'b1;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (d != LJ || oe || busy || tx_ready) bad++;
        end
        check_output("idle_stable", bad, 0);

        pkt = '{8'h00};               apply_stimulus(pkt);
        pkt = '{8'hFF};               apply_stimulus(pkt);
        pkt = '{8'hA5, 8'h3C};        apply_stimulus(pkt);
        pkt.delete();                 apply_stimulus(pkt);
        pkt = '{8'hFC};               apply_stimulus(pkt);
        pkt = '{8'hFC, 8'h01};        apply_stimulus(pkt);
        pkt = '{8'hFF, 8'hFF, 8'hFF}; apply_stimulus(pkt);

        for (int p = 0; p < 12; p++) begin
            pkt.delete();
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++)
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            repeat ($urandom_range(0, 10)) @(posedge clk);
            apply_stimulus(pkt);
        end

        // Reset during the third data bit of a two-byte packet.
        pkt = '{8'h55, 8'h55};
        build_model(pkt);
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        bad = 0;
        while (!tx_ready && bad < 600) begin
            @(negedge clk);
            bad++;
        end
        check_output("midreset_first_ready", int'(tx_ready), 1);
        repeat (40) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("midreset_d", int'(d), int'(LJ));
        check_output("midreset_oe", int'(oe), 0);
        check_output("midreset_busy", int'(busy), 0);
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) @(posedge clk);

        pkt = '{8'h5A};
        apply_stimulus(pkt);

        repeat (4) @(negedge clk);
        check_output("queues_drained", sym_q.size() + rdy_q.size() + len_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
